// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU: sequencer state
// encoding and opcode constants reused by the alu and control_unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_LOAD       = 4'd2,
    S_DECODE     = 4'd3,
    S_REG_READ   = 4'd4,
    S_EXECUTE    = 4'd5,
    S_MEM        = 4'd6,
    S_WB_RESOLVE = 4'd7,
    S_WB         = 4'd8,
    S_PC_UPDATE  = 4'd9,
    S_HALT       = 4'd10
  } state_t;

  // All-zero instruction stops the machine until the next reset.
  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h10;
  localparam logic [7:0] OP_SUB   = 8'h20;
  localparam logic [7:0] OP_LOAD  = 8'h30;
  localparam logic [7:0] OP_STORE = 8'h40;
  localparam logic [7:0] OP_JUMP  = 8'h50;

  function automatic logic is_halt(input logic [7:0] instr);
    return instr == OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of control flags, phase strobes and status between the cpu
// top level and its sequencer. The sequencer side is the master.
interface cpu_sequencer_if #(
  parameter int CNT_WIDTH = 16
);

  logic                 run;
  logic [7:0]           instruction;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 reg_w_en;
  logic                 jump;
  logic [7:0]           jump_offset;
  logic                 mem_ready;

  logic                 fetch;
  logic                 inst_load;
  logic                 decode;
  logic                 reg_read;
  logic                 execute;
  logic                 access_mem;
  logic                 wb_select;
  logic                 reg_write;
  logic [7:0]           pc;
  logic [3:0]           state;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  run, instruction, mem_r_en, mem_w_en, reg_w_en,
           jump, jump_offset, mem_ready,
    output fetch, inst_load, decode, reg_read, execute, access_mem,
           wb_select, reg_write, pc, state, halted, retired
  );

  modport slave (
    output run, instruction, mem_r_en, mem_w_en, reg_w_en,
           jump, jump_offset, mem_ready,
    input  fetch, inst_load, decode, reg_read, execute, access_mem,
           wb_select, reg_write, pc, state, halted, retired
  );

endinterface

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter register with its next-PC adder. Advances by one plus
// an optional signed jump offset, wrapping modulo 256.
module pc_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       jump,
  input  logic [7:0] jump_offset,
  output logic [7:0] pc
);

  logic [7:0] pc_q;
  logic [7:0] next_pc;

  // Two's-complement offset simply adds; carry out of bit 7 is dropped.
  always_comb begin
    next_pc = pc_q + 8'd1 + (jump ? jump_offset : 8'd0);
  end

  // PC only moves when the sequencer leaves PC_UPDATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (en) begin
      pc_q <= next_pc;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Control FSM for the multi-cycle CPU: walks each instruction through
// fetch, decode, register read, execute, memory, writeback and PC update,
// raising one strobe per phase, and counts retired instructions.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  cpu_sequencer_if.master   bus
);

  state_t               state_q;
  state_t               state_d;
  logic                 mem_first_q;
  logic                 mem_op;
  logic                 pc_en;
  logic [7:0]           pc_w;
  logic [CNT_WIDTH-1:0] retired_q;

  assign mem_op = bus.mem_r_en | bus.mem_w_en;
  assign pc_en  = (state_q == S_PC_UPDATE);

  // State register; mem_first_q marks the first cycle spent in MEM so the
  // memory strobe is a single pulse even while the access is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_first_q <= (state_q == S_EXECUTE);
    end
  end

  // Next-state logic; run is only looked at on instruction boundaries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:      state_d = S_LOAD;
      S_LOAD:       state_d = S_DECODE;
      S_DECODE:     state_d = is_halt(bus.instruction) ? S_HALT : S_REG_READ;
      S_REG_READ:   state_d = S_EXECUTE;
      S_EXECUTE:    state_d = S_MEM;
      S_MEM:        state_d = (!mem_op || bus.mem_ready) ? S_WB_RESOLVE : S_MEM;
      S_WB_RESOLVE: state_d = S_WB;
      S_WB:         state_d = S_PC_UPDATE;
      S_PC_UPDATE:  state_d = bus.run ? S_FETCH : S_IDLE;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_IDLE;
    endcase
  end

  // Retired-instruction counter, holding at all-ones once full.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (pc_en && (retired_q != '1)) begin
      retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk         (clk),
    .reset       (reset),
    .en          (pc_en),
    .jump        (bus.jump),
    .jump_offset (bus.jump_offset),
    .pc          (pc_w)
  );

  // Moore strobes decoded from the registered state.
  assign bus.fetch      = (state_q == S_FETCH);
  assign bus.inst_load  = (state_q == S_LOAD);
  assign bus.decode     = (state_q == S_DECODE);
  assign bus.reg_read   = (state_q == S_REG_READ);
  assign bus.execute    = (state_q == S_EXECUTE);
  assign bus.access_mem = (state_q == S_MEM) && mem_first_q && mem_op;
  assign bus.wb_select  = (state_q == S_WB_RESOLVE);
  assign bus.reg_write  = (state_q == S_WB) && bus.reg_w_en;
  assign bus.pc         = pc_w;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a per-cycle vector table for the
// straight-line run, then hand-written sequences for jumps, memory wait,
// pause, halt and reset during a stalled memory access.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_WIDTH(16)) bus ();

  cpu_sequencer #(
    .RESET_PC  (8'h00),
    .CNT_WIDTH (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic       run;
    logic [7:0] instruction;
    logic       reg_w_en;
    logic [3:0] exp_state;
    logic [7:0] exp_strobes;
    logic [7:0] exp_pc;
    logic [15:0] exp_retired;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic r, logic [7:0] ins, logic rw, state_t st,
                              logic [7:0] stb, logic [7:0] p, logic [15:0] ret);
    vec_t v;
    v.run = r; v.instruction = ins; v.reg_w_en = rw;
    v.exp_state = st; v.exp_strobes = stb; v.exp_pc = p; v.exp_retired = ret;
    return v;
  endfunction

  function automatic logic [7:0] strobes();
    return {bus.fetch, bus.inst_load, bus.decode, bus.reg_read,
            bus.execute, bus.access_mem, bus.wb_select, bus.reg_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.run         = v.run;
    bus.instruction = v.instruction;
    bus.reg_w_en    = v.reg_w_en;
    bus.mem_r_en    = 1'b0;
    bus.mem_w_en    = 1'b0;
    bus.jump        = 1'b0;
    bus.jump_offset = 8'h00;
    bus.mem_ready   = 1'b1;
  endtask

  // Runs one instruction from FETCH through the PC_UPDATE exit edge.
  task automatic do_instr(input logic [7:0] ins, input logic j, input logic [7:0] off,
                          input logic mr, input logic rw, input int ready_low,
                          output int cycles, output int n_acc, output int n_rw,
                          output int n_mem);
    int low;
    low = 0;
    bus.instruction = ins; bus.jump = j; bus.jump_offset = off;
    bus.mem_r_en = mr; bus.mem_w_en = 1'b0; bus.reg_w_en = rw; bus.mem_ready = 1'b1;
    cycles = 1; n_acc = 0; n_rw = 0; n_mem = 0;
    while (bus.state != S_PC_UPDATE && cycles < 40) begin
      if (bus.state == S_MEM && low < ready_low) begin
        bus.mem_ready = 1'b0;
        low++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      tick();
      cycles++;
      n_acc += int'(bus.access_mem);
      n_rw  += int'(bus.reg_write);
      n_mem += int'(bus.state == S_MEM);
    end
    if (cycles >= 40) checkOutput("instr_timeout", 32'(cycles), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, nacc, nrw, nmem, nfetch;
    logic [7:0] pc_hold;
    logic [15:0] ret_hold;

    // Straight-line run of 8'h15: two instructions, 9 cycles each.
    vecs[0]  = mk(1, 8'h15, 1, S_FETCH,      8'b1000_0000, 8'h00, 16'd0);
    vecs[1]  = mk(1, 8'h15, 1, S_LOAD,       8'b0100_0000, 8'h00, 16'd0);
    vecs[2]  = mk(1, 8'h15, 1, S_DECODE,     8'b0010_0000, 8'h00, 16'd0);
    vecs[3]  = mk(1, 8'h15, 1, S_REG_READ,   8'b0001_0000, 8'h00, 16'd0);
    vecs[4]  = mk(1, 8'h15, 1, S_EXECUTE,    8'b0000_1000, 8'h00, 16'd0);
    vecs[5]  = mk(1, 8'h15, 1, S_MEM,        8'b0000_0000, 8'h00, 16'd0);
    vecs[6]  = mk(1, 8'h15, 1, S_WB_RESOLVE, 8'b0000_0010, 8'h00, 16'd0);
    vecs[7]  = mk(1, 8'h15, 1, S_WB,         8'b0000_0001, 8'h00, 16'd0);
    vecs[8]  = mk(1, 8'h15, 1, S_PC_UPDATE,  8'b0000_0000, 8'h00, 16'd0);
    vecs[9]  = mk(1, 8'h15, 1, S_FETCH,      8'b1000_0000, 8'h01, 16'd1);
    vecs[10] = mk(1, 8'h15, 1, S_LOAD,       8'b0100_0000, 8'h01, 16'd1);
    vecs[11] = mk(1, 8'h15, 1, S_DECODE,     8'b0010_0000, 8'h01, 16'd1);
    vecs[12] = mk(1, 8'h15, 1, S_REG_READ,   8'b0001_0000, 8'h01, 16'd1);
    vecs[13] = mk(1, 8'h15, 1, S_EXECUTE,    8'b0000_1000, 8'h01, 16'd1);
    vecs[14] = mk(1, 8'h15, 1, S_MEM,        8'b0000_0000, 8'h01, 16'd1);
    vecs[15] = mk(1, 8'h15, 1, S_WB_RESOLVE, 8'b0000_0010, 8'h01, 16'd1);
    vecs[16] = mk(1, 8'h15, 1, S_WB,         8'b0000_0001, 8'h01, 16'd1);
    vecs[17] = mk(1, 8'h15, 1, S_PC_UPDATE,  8'b0000_0000, 8'h01, 16'd1);
    vecs[18] = mk(1, 8'h15, 1, S_FETCH,      8'b1000_0000, 8'h02, 16'd2);

    // Reset state
    bus.run = 1'b0; bus.instruction = 8'h15; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.reg_w_en = 1'b0; bus.jump = 1'b0; bus.jump_offset = 8'h00; bus.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_state",   32'(bus.state),   32'(S_IDLE));
    checkOutput("rst_pc",      32'(bus.pc),      32'h00);
    checkOutput("rst_retired", 32'(bus.retired), 32'd0);
    checkOutput("rst_halted",  32'(bus.halted),  32'd0);
    checkOutput("rst_strobes", 32'(strobes()),   32'd0);
    reset = 1'b0;
    tick();
    checkOutput("idle_hold", 32'(bus.state), 32'(S_IDLE));

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_state", i),   32'(bus.state),   32'(vecs[i].exp_state));
      checkOutput($sformatf("vec%0d_strobes", i), 32'(strobes()),   32'(vecs[i].exp_strobes));
      checkOutput($sformatf("vec%0d_pc", i),      32'(bus.pc),      32'(vecs[i].exp_pc));
      checkOutput($sformatf("vec%0d_retired", i), 32'(bus.retired), 32'(vecs[i].exp_retired));
    end

    // Jumps: 02 +1 +FB = FE, FE +1 +03 wraps to 02, 02 +1 +FE = 01
    do_instr(8'h50, 1'b1, 8'hFB, 1'b0, 1'b0, 0, cyc, nacc, nrw, nmem);
    checkOutput("jmp_to_fe", 32'(bus.pc), 32'hFE);
    do_instr(8'h50, 1'b1, 8'h03, 1'b0, 1'b0, 0, cyc, nacc, nrw, nmem);
    checkOutput("jmp_wrap_pc", 32'(bus.pc), 32'h02);
    checkOutput("jmp_cycles",  32'(cyc),    32'd9);
    do_instr(8'h50, 1'b1, 8'hFE, 1'b0, 1'b0, 0, cyc, nacc, nrw, nmem);
    checkOutput("jmp_back_pc", 32'(bus.pc), 32'h01);

    // Memory read stalled by three low mem_ready cycles
    do_instr(8'h30, 1'b0, 8'h00, 1'b1, 1'b1, 3, cyc, nacc, nrw, nmem);
    checkOutput("mem_cycles",     32'(cyc),         32'd12);
    checkOutput("mem_access_cnt", 32'(nacc),        32'd1);
    checkOutput("mem_hold_cnt",   32'(nmem),        32'd4);
    checkOutput("mem_regwr_cnt",  32'(nrw),         32'd1);
    checkOutput("mem_pc",         32'(bus.pc),      32'h02);
    checkOutput("mem_retired",    32'(bus.retired), 32'd6);

    // Pause: drop run during EXECUTE, instruction still completes
    bus.instruction = 8'h15; bus.mem_r_en = 1'b0; bus.jump = 1'b0; bus.reg_w_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("pause_in_exec", 32'(bus.state), 32'(S_EXECUTE));
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("pause_state",   32'(bus.state),   32'(S_IDLE));
    checkOutput("pause_retired", 32'(bus.retired), 32'd7);
    checkOutput("pause_pc",      32'(bus.pc),      32'h03);
    nfetch = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nfetch += int'(bus.fetch);
    end
    checkOutput("pause_no_fetch", 32'(nfetch), 32'd0);
    bus.run = 1'b1;
    tick();
    checkOutput("resume_state", 32'(bus.state), 32'(S_FETCH));
    checkOutput("resume_pc",    32'(bus.pc),    32'h03);

    // Halt on the all-zero instruction
    bus.instruction = 8'h00;
    tick(); tick(); tick();
    checkOutput("halt_state",  32'(bus.state),  32'(S_HALT));
    checkOutput("halt_halted", 32'(bus.halted), 32'd1);
    pc_hold = bus.pc;
    ret_hold = bus.retired;
    nfetch = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      nfetch += int'(bus.fetch);
    end
    checkOutput("halt_stay",     32'(bus.state),   32'(S_HALT));
    checkOutput("halt_pc",       32'(bus.pc),      32'h03);
    checkOutput("halt_pc_hold",  32'(bus.pc),      32'(pc_hold));
    checkOutput("halt_retired",  32'(bus.retired), 32'd7);
    checkOutput("halt_ret_hold", 32'(bus.retired), 32'(ret_hold));
    checkOutput("halt_no_fetch", 32'(nfetch),      32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("halt_rst_state", 32'(bus.state),   32'(S_IDLE));
    checkOutput("halt_rst_pc",    32'(bus.pc),      32'h00);
    checkOutput("halt_rst_ret",   32'(bus.retired), 32'd0);
    checkOutput("halt_rst_flag",  32'(bus.halted),  32'd0);

    // Reset while stalled in MEM
    bus.instruction = 8'h30; bus.mem_r_en = 1'b1; bus.reg_w_en = 1'b1; bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    nrw = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nrw += int'(bus.reg_write);
    end
    checkOutput("stall_state", 32'(bus.state), 32'(S_MEM));
    reset = 1'b1;
    tick();
    nrw += int'(bus.reg_write);
    checkOutput("mrst_state",   32'(bus.state),   32'(S_IDLE));
    checkOutput("mrst_strobes", 32'(strobes()),   32'd0);
    checkOutput("mrst_pc",      32'(bus.pc),      32'h00);
    checkOutput("mrst_retired", 32'(bus.retired), 32'd0);
    checkOutput("mrst_halted",  32'(bus.halted),  32'd0);
    checkOutput("mrst_no_regwr", 32'(nrw),        32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Clocked control FSM for the 8-bit multi-cycle CPU. It sequences fetch, decode, register read, execute, data-memory access, writeback and PC update, issuing one strobe per phase. It owns the program counter, halts on the all-zero instruction, and pauses at instruction boundaries under `run`. It sits between the top-level `cpu` and the `instruction_mem`, `control_unit`, `alu` and `data_memory` blocks. It replaces the delay-driven state walk with a synthesizable one-clock design.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset
- `CNT_WIDTH`, 16, width of the retired-instruction counter
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge
- `run`  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- `instruction`  in  8  current instruction register value
- `mem_r_en`, `mem_w_en`, `reg_w_en`  in  1 each  control_unit flags for current instruction
- `jump`  in  1  taken jump/branch for current instruction
- `jump_offset`  in  8  PC offset, two's-complement, added when `jump`=1
- `mem_ready`  in  1  data_memory completion; may be tied high
- `fetch`, `inst_load`, `decode`, `reg_read`, `execute`, `access_mem`, `wb_select`, `reg_write`  out  1 each  phase strobes
- `pc`  out  8  program counter to instruction_mem
- `state`  out  4  current FSM state (debug)
- `halted`  out  1  1 while in HALT
- `retired`  out  CNT_WIDTH  instructions completed, saturating

## Operation
- States: IDLE, FETCH, LOAD, DECODE, REG_READ, EXECUTE, MEM, WB_RESOLVE, WB, PC_UPDATE, HALT.
- Strobes are Moore decodes of the state register; each is high only in its state:
  - `fetch` in FETCH, `inst_load` in LOAD, `decode` in DECODE, `reg_read` in REG_READ, `execute` in EXECUTE, `wb_select` in WB_RESOLVE.
  - `access_mem` in the first MEM cycle only, and only if `mem_r_en|mem_w_en`.
  - `reg_write` in WB only if `reg_w_en`.
- Transitions:
  - IDLE→FETCH when `run`=1, else stay.
  - FETCH→LOAD→DECODE.
  - DECODE→HALT if `instruction`==8'h00, else →REG_READ.
  - REG_READ→EXECUTE→MEM.
  - MEM→WB_RESOLVE when no memory op, or when `mem_ready`=1 (sampled from the first MEM cycle on); otherwise hold in MEM.
  - WB_RESOLVE→WB→PC_UPDATE.
  - PC_UPDATE→FETCH if `run`=1, else →IDLE.
  - HALT is terminal; only `reset` leaves it.
- PC arithmetic: on PC_UPDATE exit, `pc` ← `pc` + 1 + (`jump` ? `jump_offset` : 0), modulo 256, wrapping silently (8'hFF+1 → 8'h00). `pc` is unchanged in every other state.
- `retired` increments on PC_UPDATE exit and saturates at all-ones. The halting instruction is not counted.
- `run` is sampled only in IDLE and PC_UPDATE. Deasserting it mid-instruction completes the current instruction.

## Timing
- Reset: `state`=IDLE, `pc`=RESET_PC, `retired`=0, `halted`=0, all strobes 0 in the cycle after `reset` is sampled high. Reset overrides every state, including MEM wait and HALT, with no partial writeback.
- Latency: 9 cycles per instruction from FETCH to PC_UPDATE with `mem_ready` high. Each low cycle of `mem_ready` during a memory op adds one cycle.
- `inst_load` falls one cycle after `fetch`, giving instruction_mem one cycle of read time. Flags from control_unit are valid from REG_READ onward.
- `mem_ready` high in the same cycle as `access_mem` completes MEM in one cycle.
- IDLE→FETCH takes 1 cycle after `run` rises.

## Structure
- A shared package `cpu_pkg` holds the 4-bit state enum and opcode constants (halt encoding 8'h00). `alu` and `control_unit` reuse the opcode constants.
- One natural sub-module: `pc_unit` (PC register, next-PC adder, reset load), enabled by the FSM in PC_UPDATE.
- `retired` counter stays inline.

## Test plan
- **Straight-line run:** reset, `run`=1, non-memory instruction 8'h15, `jump`=0, `mem_ready`=1. Required: strobes in order FETCH…PC_UPDATE, 9 cycles per instruction, `pc` 00→01→02, `retired`=2 after 18 cycles.
- **Jump with wrap:** `pc`=8'hFE, `jump`=1, `jump_offset`=8'h03. Required: `pc`=8'h02 after PC_UPDATE. Then `jump_offset`=8'hFE (−2) at `pc`=8'h02: `pc`=8'h01.
- **Memory wait:** `mem_r_en`=1, `mem_ready` low for 3 cycles. Required: `access_mem` high exactly 1 cycle, MEM held 4 cycles, instruction takes 12 cycles, `reg_write` pulses once.
- **Halt:** `instruction`=8'h00 at DECODE. Required: next state HALT, `halted`=1, `pc` and `retired` frozen for 20+ cycles with `run`=1. `reset` returns to IDLE with `pc`=RESET_PC.
- **Pause:** drop `run` during EXECUTE. Required: instruction completes, `retired`+1, state IDLE, no `fetch`. Raising `run` resumes FETCH at next `pc`.
- **Reset mid-MEM:** assert `reset` while stalled in MEM. Required: IDLE next cycle, `reg_write` never asserted, all outputs at reset values.
